// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: state encoding, step-count
// helper and the parameter legality check used at elaboration.
package digit_serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of digit steps needed to cover the full operand width.
    function automatic int unsigned steps_of(input int unsigned width,
                                             input int unsigned digit);
        return width / digit;
    endfunction

    // Legal configuration: at least one bit per digit, digit fits the word,
    // and the word splits into whole digits.
    function automatic bit cfg_ok(input int unsigned width,
                                  input int unsigned digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells.
// Ports:
//   x, y      in   DIGIT-bit addends
//   ci        in   carry into bit 0
//   sum       out  DIGIT-bit sum
//   co        out  carry out of the top bit
//   c_msb_in  out  carry into the top bit (for signed overflow)
module digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    // Ripple chain; c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, LSB digit first, returning sum, carry-out and signed overflow
// through valid/ready handshakes.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (s, cout, ovf)
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = steps_of(WIDTH, DIGIT);
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT, DIGIT >= 1");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   dig_x, dig_y, dig_sum;
    logic               dig_co, dig_cmsb;

    // Current digit of the latched operands.
    assign dig_x = a_q[cnt_q*DIGIT +: DIGIT];
    assign dig_y = b_q[cnt_q*DIGIT +: DIGIT];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x        (dig_x),
        .y        (dig_y),
        .ci       (carry_q),
        .sum      (dig_sum),
        .co       (dig_co),
        .c_msb_in (dig_cmsb)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[cnt_q*DIGIT +: DIGIT] = dig_sum;
                carry_d = dig_co;
                // Final digit holds the MSB: capture carry-out and overflow.
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    cout_d  = dig_co;
                    ovf_d   = dig_co ^ dig_cmsb;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gated by rst_n so in_ready reads low while reset is asserted.
    assign in_ready  = rst_n & (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
